// File: rtl/wbu_writeback_sequencer_if.sv
// Write-back bus: instruction handshake from the memory stage plus the GPR/CSR
// write ports and retire/difftest signals that the write-back stage drives.
interface wbu_writeback_sequencer_if;
    logic        MEM_i_valid;
    logic        WB_o_ready;
    logic [31:0] MEM_i_pc;
    logic [31:0] MEM_i_inst;
    logic        MEM_i_commit;
    logic [4:0]  MEM_i_rd;
    logic [2:0]  MEM_i_csr_rd;
    logic        MEM_i_write_gpr;
    logic        MEM_i_write_csr;
    logic        MEM_i_mem_to_reg;
    logic        MEM_i_rv32_csrrw;
    logic        MEM_i_rv32_csrrs;
    logic        MEM_i_rv32_ecall;
    logic        MEM_i_system_halt;
    logic [31:0] MEM_i_alu_result;
    logic [31:0] MEM_i_mem_rdata;
    logic [31:0] MEM_i_csr_rs_data;

    logic [4:0]  WB_o_rd;
    logic        WB_o_RegWr;
    logic [31:0] WB_o_rf_busW;
    logic [2:0]  WB_o_csr_rd;
    logic        WB_o_CSRWr;
    logic [31:0] WB_o_csr_busW;
    logic        WB_o_commit;
    logic [31:0] WB_o_pc;
    logic [31:0] WB_o_inst;
    logic        WB_o_halt;

    modport master (
        output MEM_i_valid, MEM_i_pc, MEM_i_inst, MEM_i_commit, MEM_i_rd, MEM_i_csr_rd,
               MEM_i_write_gpr, MEM_i_write_csr, MEM_i_mem_to_reg, MEM_i_rv32_csrrw,
               MEM_i_rv32_csrrs, MEM_i_rv32_ecall, MEM_i_system_halt, MEM_i_alu_result,
               MEM_i_mem_rdata, MEM_i_csr_rs_data,
        input  WB_o_ready, WB_o_rd, WB_o_RegWr, WB_o_rf_busW, WB_o_csr_rd, WB_o_CSRWr,
               WB_o_csr_busW, WB_o_commit, WB_o_pc, WB_o_inst, WB_o_halt
    );

    modport slave (
        input  MEM_i_valid, MEM_i_pc, MEM_i_inst, MEM_i_commit, MEM_i_rd, MEM_i_csr_rd,
               MEM_i_write_gpr, MEM_i_write_csr, MEM_i_mem_to_reg, MEM_i_rv32_csrrw,
               MEM_i_rv32_csrrs, MEM_i_rv32_ecall, MEM_i_system_halt, MEM_i_alu_result,
               MEM_i_mem_rdata, MEM_i_csr_rs_data,
        output WB_o_ready, WB_o_rd, WB_o_RegWr, WB_o_rf_busW, WB_o_csr_rd, WB_o_CSRWr,
               WB_o_csr_busW, WB_o_commit, WB_o_pc, WB_o_inst, WB_o_halt
    );
endinterface

// File: rtl/wbu_writeback_sequencer.sv
// Write-back stage: registers one retired instruction per handshake and drives the
// GPR/CSR write ports one cycle later; ecall is split into mepc then mcause writes.
module wbu_writeback_sequencer #(
    parameter logic [2:0]  CSR_MEPC    = 3'd3,
    parameter logic [2:0]  CSR_MCAUSE  = 3'd4,
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input logic                      clk,
    input logic                      rst,
    wbu_writeback_sequencer_if.slave wb_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_ECALL2,
        S_HALTED
    } state_e;

    state_e      state_q, state_d;
    logic        ecall_pend_q, ecall_pend_d;
    logic        halt_pend_q, halt_pend_d;
    logic        regwr_q, regwr_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rf_busw_q, rf_busw_d;
    logic        csrwr_q, csrwr_d;
    logic [2:0]  csr_rd_q, csr_rd_d;
    logic [31:0] csr_busw_q, csr_busw_d;
    logic        commit_q, commit_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        halt_q, halt_d;

    logic        ready;
    logic        accept;
    logic [31:0] gpr_result;

    always_comb begin
        if (wb_if.MEM_i_rv32_csrrw || wb_if.MEM_i_rv32_csrrs) begin
            gpr_result = wb_if.MEM_i_csr_rs_data;
        end else if (wb_if.MEM_i_mem_to_reg) begin
            gpr_result = wb_if.MEM_i_mem_rdata;
        end else begin
            gpr_result = wb_if.MEM_i_alu_result;
        end
    end

    // A WRITE cycle holding an ecall or a halt refuses new work: the ecall needs the
    // next cycle for its mcause write, and a halting instruction must be the last one.
    always_comb begin
        ready  = (state_q == S_IDLE) ||
                 ((state_q == S_WRITE) && !ecall_pend_q && !halt_pend_q);
        accept = wb_if.MEM_i_valid && ready;
    end

    always_comb begin
        // NOTE: every *_d is given a default before the case so that no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        ecall_pend_d = 1'b0;
        halt_pend_d  = 1'b0;
        regwr_d      = 1'b0;
        csrwr_d      = 1'b0;
        commit_d     = 1'b0;
        rd_d         = rd_q;
        rf_busw_d    = rf_busw_q;
        csr_rd_d     = csr_rd_q;
        csr_busw_d   = csr_busw_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        halt_d       = halt_q;

        unique case (state_q)
            S_IDLE, S_WRITE: begin
                if (ecall_pend_q) begin
                    state_d    = S_ECALL2;
                    csrwr_d    = 1'b1;
                    csr_rd_d   = CSR_MCAUSE;
                    csr_busw_d = ECALL_CAUSE;
                end else if (halt_pend_q) begin
                    state_d = S_HALTED;
                end else if (accept) begin
                    state_d  = S_WRITE;
                    pc_d     = wb_if.MEM_i_pc;
                    inst_d   = wb_if.MEM_i_inst;
                    commit_d = wb_if.MEM_i_commit;
                    if (wb_if.MEM_i_commit) begin
                        if (wb_if.MEM_i_rv32_ecall) begin
                            ecall_pend_d = 1'b1;
                            csrwr_d      = 1'b1;
                            csr_rd_d     = CSR_MEPC;
                            csr_busw_d   = wb_if.MEM_i_pc;
                        end else begin
                            if (wb_if.MEM_i_write_gpr && (wb_if.MEM_i_rd != 5'd0)) begin
                                regwr_d   = 1'b1;
                                rd_d      = wb_if.MEM_i_rd;
                                rf_busw_d = gpr_result;
                            end
                            if (wb_if.MEM_i_write_csr) begin
                                csrwr_d    = 1'b1;
                                csr_rd_d   = wb_if.MEM_i_csr_rd;
                                csr_busw_d = wb_if.MEM_i_alu_result;
                            end
                            if (wb_if.MEM_i_system_halt) begin
                                halt_pend_d = 1'b1;
                                halt_d      = 1'b1;
                            end
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ECALL2: state_d = S_IDLE;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values,
        // independent of statement order inside this block.
        if (rst) begin
            state_q      <= S_IDLE;
            ecall_pend_q <= 1'b0;
            halt_pend_q  <= 1'b0;
            regwr_q      <= 1'b0;
            rd_q         <= 5'd0;
            rf_busw_q    <= 32'd0;
            csrwr_q      <= 1'b0;
            csr_rd_q     <= 3'd0;
            csr_busw_q   <= 32'd0;
            commit_q     <= 1'b0;
            pc_q         <= 32'd0;
            inst_q       <= 32'd0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ecall_pend_q <= ecall_pend_d;
            halt_pend_q  <= halt_pend_d;
            regwr_q      <= regwr_d;
            rd_q         <= rd_d;
            rf_busw_q    <= rf_busw_d;
            csrwr_q      <= csrwr_d;
            csr_rd_q     <= csr_rd_d;
            csr_busw_q   <= csr_busw_d;
            commit_q     <= commit_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            halt_q       <= halt_d;
        end
    end

    assign wb_if.WB_o_ready    = ready;
    assign wb_if.WB_o_rd       = rd_q;
    assign wb_if.WB_o_RegWr    = regwr_q;
    assign wb_if.WB_o_rf_busW  = rf_busw_q;
    assign wb_if.WB_o_csr_rd   = csr_rd_q;
    assign wb_if.WB_o_CSRWr    = csrwr_q;
    assign wb_if.WB_o_csr_busW = csr_busw_q;
    assign wb_if.WB_o_commit   = commit_q;
    assign wb_if.WB_o_pc       = pc_q;
    assign wb_if.WB_o_inst     = inst_q;
    assign wb_if.WB_o_halt     = halt_q;

endmodule

// File: tb/tb_wbu_writeback_sequencer.sv
// Bench for wbu_writeback_sequencer: each retired instruction is turned into a queue of
// expected per-cycle write effects, and the DUT outputs are compared every cycle.
module tb_wbu_writeback_sequencer;

    localparam logic [2:0]  MEPC  = 3'd3;
    localparam logic [2:0]  MCAUS = 3'd4;
    localparam logic [31:0] CAUSE = 32'd11;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        commit;
        logic [4:0]  rd;
        logic [2:0]  csr_rd;
        logic        write_gpr;
        logic        write_csr;
        logic        mem_to_reg;
        logic        csrrw;
        logic        csrrs;
        logic        ecall;
        logic        halt;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] rs_data;
    } insn_t;

    typedef struct packed {
        logic        regwr;
        logic [4:0]  rd;
        logic [31:0] rf_busw;
        logic        csrwr;
        logic [2:0]  csr_rd;
        logic [31:0] csr_busw;
        logic        commit;
        logic        busy;
    } eff_t;

    typedef struct packed {
        logic        regwr;
        logic [4:0]  rd;
        logic [31:0] rf_busw;
        logic        csrwr;
        logic [2:0]  csr_rd;
        logic [31:0] csr_busw;
        logic        commit;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        halt;
        logic        ready;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wbu_writeback_sequencer_if bus ();

    wbu_writeback_sequencer #(
        .CSR_MEPC    (MEPC),
        .CSR_MCAUSE  (MCAUS),
        .ECALL_CAUSE (CAUSE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .wb_if (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending per-cycle effects plus the last value seen on each bus.
    eff_t        pending[$];
    logic [4:0]  m_rd;
    logic [31:0] m_rf_busw;
    logic [2:0]  m_csr_rd;
    logic [31:0] m_csr_busw;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_halt;

    task automatic model_clear();
        pending.delete();
        m_rd = '0; m_rf_busw = '0; m_csr_rd = '0; m_csr_busw = '0;
        m_pc = '0; m_inst = '0; m_halt = 1'b0;
    endtask

    task automatic push_effects(input insn_t i);
        eff_t f;
        f = '0;
        if (!i.commit) begin
            pending.push_back(f);
        end else if (i.ecall) begin
            f.commit = 1'b1; f.busy = 1'b1;
            f.csrwr = 1'b1; f.csr_rd = MEPC; f.csr_busw = i.pc;
            pending.push_back(f);
            f = '0;
            f.busy = 1'b1; f.csrwr = 1'b1; f.csr_rd = MCAUS; f.csr_busw = CAUSE;
            pending.push_back(f);
        end else begin
            f.commit = 1'b1;
            if (i.write_gpr && i.rd != 5'd0) begin
                f.regwr = 1'b1;
                f.rd    = i.rd;
                f.rf_busw = (i.csrrw || i.csrrs) ? i.rs_data : (i.mem_to_reg ? i.rdata : i.alu);
            end
            if (i.write_csr) begin
                f.csrwr = 1'b1; f.csr_rd = i.csr_rd; f.csr_busw = i.alu;
            end
            if (i.halt) begin
                f.busy = 1'b1;
                m_halt = 1'b1;
            end
            pending.push_back(f);
        end
    endtask

    task automatic drive(input insn_t i, input logic v);
        bus.MEM_i_valid       = v;
        bus.MEM_i_pc          = i.pc;
        bus.MEM_i_inst        = i.inst;
        bus.MEM_i_commit      = i.commit;
        bus.MEM_i_rd          = i.rd;
        bus.MEM_i_csr_rd      = i.csr_rd;
        bus.MEM_i_write_gpr   = i.write_gpr;
        bus.MEM_i_write_csr   = i.write_csr;
        bus.MEM_i_mem_to_reg  = i.mem_to_reg;
        bus.MEM_i_rv32_csrrw  = i.csrrw;
        bus.MEM_i_rv32_csrrs  = i.csrrs;
        bus.MEM_i_rv32_ecall  = i.ecall;
        bus.MEM_i_system_halt = i.halt;
        bus.MEM_i_alu_result  = i.alu;
        bus.MEM_i_mem_rdata   = i.rdata;
        bus.MEM_i_csr_rs_data = i.rs_data;
    endtask

    // One clock cycle, entered and left at a falling edge: returns what the model expects
    // now and what the DUT shows now, then presents the given inputs to the next rising edge.
    task automatic step(input insn_t i, input logic v, input logic do_rst,
                        output obs_t e, output obs_t a, output logic acc);
        eff_t cur;
        cur = '0;
        if (pending.size() > 0) cur = pending.pop_front();
        if (cur.regwr) begin m_rd = cur.rd; m_rf_busw = cur.rf_busw; end
        if (cur.csrwr) begin m_csr_rd = cur.csr_rd; m_csr_busw = cur.csr_busw; end
        e = '{regwr: cur.regwr, rd: m_rd, rf_busw: m_rf_busw, csrwr: cur.csrwr,
              csr_rd: m_csr_rd, csr_busw: m_csr_busw, commit: cur.commit, pc: m_pc,
              inst: m_inst, halt: m_halt, ready: !cur.busy && !m_halt};
        a = '{regwr: bus.WB_o_RegWr, rd: bus.WB_o_rd, rf_busw: bus.WB_o_rf_busW,
              csrwr: bus.WB_o_CSRWr, csr_rd: bus.WB_o_csr_rd, csr_busw: bus.WB_o_csr_busW,
              commit: bus.WB_o_commit, pc: bus.WB_o_pc, inst: bus.WB_o_inst,
              halt: bus.WB_o_halt, ready: bus.WB_o_ready};
        drive(i, v);
        rst = do_rst;
        acc = v && e.ready && !do_rst;
        @(posedge clk);
        if (do_rst) begin
            model_clear();
        end else if (acc) begin
            push_effects(i);
            m_pc   = i.pc;
            m_inst = i.inst;
        end
        @(negedge clk);
    endtask

    function automatic insn_t rand_insn(input logic allow_ecall);
        insn_t i;
        i.pc         = $urandom() & 32'hFFFF_FFFC;
        i.inst       = $urandom();
        i.commit     = ($urandom_range(0, 3) != 0);
        i.rd         = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom());
        i.csr_rd     = 3'($urandom());
        i.write_gpr  = 1'($urandom());
        i.write_csr  = 1'($urandom());
        i.mem_to_reg = 1'($urandom());
        i.csrrw      = ($urandom_range(0, 3) == 0);
        i.csrrs      = ($urandom_range(0, 3) == 0);
        i.ecall      = allow_ecall && ($urandom_range(0, 7) == 0);
        i.halt       = 1'b0;
        i.alu        = $urandom();
        i.rdata      = $urandom();
        i.rs_data    = $urandom();
        return i;
    endfunction

    insn_t idle_i = '0;

    task automatic test_reset();
        obs_t e, a;
        logic acc;
        insn_t i;
        i = rand_insn(1'b0);
        i.commit = 1'b1; i.write_gpr = 1'b1; i.rd = 5'd9;
        // valid together with rst: nothing may be captured
        step(i, 1'b1, 1'b1, e, a, acc);
        n_checks++;
        if (a !== obs_t'({141'd0} | 141'd1)) $display("FAIL reset_state: got %h want %h", a, 141'd1);
        else n_pass++;
        step(idle_i, 1'b0, 1'b0, e, a, acc);
        n_checks++;
        if (a !== e || a.regwr !== 1'b0 || a.ready !== 1'b1 || a.pc !== 32'd0)
            $display("FAIL reset_wins_over_valid: got %h want %h", a, e);
        else n_pass++;
    endtask

    task automatic test_add();
        obs_t e, a;
        logic acc;
        insn_t i;
        i = '0;
        i.pc = 32'h8000_0000; i.inst = 32'h0000_02B3; i.commit = 1'b1;
        i.write_gpr = 1'b1; i.rd = 5'd5; i.alu = 32'h1234;
        step(i, 1'b1, 1'b0, e, a, acc);
        step(idle_i, 1'b0, 1'b0, e, a, acc);
        n_checks++;
        if (a !== e || {a.regwr, a.rd, a.rf_busw, a.commit, a.pc} !==
                       {1'b1, 5'd5, 32'h1234, 1'b1, 32'h8000_0000})
            $display("FAIL add_write: got %h want %h", a, e);
        else n_pass++;
        step(idle_i, 1'b0, 1'b0, e, a, acc);
        n_checks++;
        if (a !== e || a.regwr !== 1'b0 || a.commit !== 1'b0 || a.rf_busw !== 32'h1234)
            $display("FAIL add_strobe_drop: got %h want %h", a, e);
        else n_pass++;
    endtask

    task automatic test_load_x0();
        obs_t e, a;
        logic acc;
        insn_t i;
        i = '0;
        i.pc = 32'h8000_0004; i.commit = 1'b1; i.write_gpr = 1'b1;
        i.mem_to_reg = 1'b1; i.rd = 5'd0; i.rdata = 32'hFFFF_FF80; i.alu = 32'h10;
        step(i, 1'b1, 1'b0, e, a, acc);
        step(idle_i, 1'b0, 1'b0, e, a, acc);
        n_checks++;
        if (a !== e || a.regwr !== 1'b0 || a.commit !== 1'b1)
            $display("FAIL load_x0: got %h want %h", a, e);
        else n_pass++;
    endtask

    task automatic test_csrrw();
        obs_t e, a;
        logic acc;
        insn_t i;
        i = '0;
        i.pc = 32'h8000_0008; i.commit = 1'b1; i.csrrw = 1'b1;
        i.write_gpr = 1'b1; i.write_csr = 1'b1; i.rd = 5'd7; i.csr_rd = 3'd3;
        i.rs_data = 32'hAA; i.alu = 32'h55; i.rdata = 32'h77; i.mem_to_reg = 1'b1;
        step(i, 1'b1, 1'b0, e, a, acc);
        step(idle_i, 1'b0, 1'b0, e, a, acc);
        n_checks++;
        if (a !== e || {a.regwr, a.rd, a.rf_busw, a.csrwr, a.csr_rd, a.csr_busw} !==
                       {1'b1, 5'd7, 32'hAA, 1'b1, 3'd3, 32'h55})
            $display("FAIL csrrw_dual_write: got %h want %h", a, e);
        else n_pass++;
    endtask

    task automatic test_ecall();
        obs_t e, a;
        logic acc;
        insn_t ec, nx;
        int commits;
        ec = '0;
        ec.pc = 32'h8000_0010; ec.inst = 32'h0000_0073; ec.commit = 1'b1; ec.ecall = 1'b1;
        ec.write_gpr = 1'b1; ec.rd = 5'd3;
        nx = rand_insn(1'b0);
        nx.commit = 1'b1; nx.write_gpr = 1'b1; nx.rd = 5'd12; nx.ecall = 1'b0;
        commits = 0;
        step(ec, 1'b1, 1'b0, e, a, acc);
        step(nx, 1'b1, 1'b0, e, a, acc);
        commits += int'(a.commit);
        n_checks++;
        if (a !== e || {a.csrwr, a.csr_rd, a.csr_busw, a.ready, a.regwr} !==
                       {1'b1, 3'd3, 32'h8000_0010, 1'b0, 1'b0})
            $display("FAIL ecall_mepc: got %h want %h", a, e);
        else n_pass++;
        step(nx, 1'b1, 1'b0, e, a, acc);
        commits += int'(a.commit);
        n_checks++;
        if (a !== e || {a.csrwr, a.csr_rd, a.csr_busw, a.ready} !== {1'b1, 3'd4, 32'd11, 1'b0})
            $display("FAIL ecall_mcause: got %h want %h", a, e);
        else n_pass++;
        step(nx, 1'b1, 1'b0, e, a, acc);
        commits += int'(a.commit);
        n_checks++;
        if (a !== e || a.ready !== 1'b1 || a.csrwr !== 1'b0)
            $display("FAIL ecall_ready_back: got %h want %h", a, e);
        else n_pass++;
        n_checks++;
        if (commits !== 1) $display("FAIL ecall_commit_count: got %0d want 1", commits);
        else n_pass++;
        step(idle_i, 1'b0, 1'b0, e, a, acc);
        n_checks++;
        if (a !== e || a.regwr !== 1'b1 || a.rd !== 5'd12 || a.pc !== nx.pc)
            $display("FAIL ecall_next_accepted: got %h want %h", a, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        obs_t e, a;
        logic acc;
        insn_t i;
        logic [3:0] pat, wr;
        int fails;
        pat = '0; wr = '0; fails = 0;
        for (int k = 0; k < 5; k++) begin
            i = rand_insn(1'b0);
            i.commit = (k != 1); i.write_gpr = 1'b1; i.rd = 5'(k + 1); i.write_csr = 1'b0;
            step(i, (k < 4), 1'b0, e, a, acc);
            if (k > 0) begin
                pat = {pat[2:0], a.commit};
                wr  = {wr[2:0], a.regwr};
                if (a !== e) fails++;
            end
        end
        n_checks++;
        if (fails != 0 || pat !== 4'b1011 || wr !== 4'b1011)
            $display("FAIL back_to_back: got commit %b regwr %b (%0d cycle diffs) want 1011 1011",
                     pat, wr, fails);
        else n_pass++;
    endtask

    task automatic test_random();
        obs_t e, a;
        logic acc;
        int fails;
        fails = 0;
        for (int k = 0; k < 400; k++) begin
            step(rand_insn(1'b1), ($urandom_range(0, 9) < 7) && (k < 390), 1'b0, e, a, acc);
            n_checks++;
            if (a !== e) begin
                fails++;
                if (fails < 10) $display("FAIL random_cycle_%0d: got %h want %h", k, a, e);
            end else n_pass++;
        end
    endtask

    task automatic test_halt();
        obs_t e, a;
        logic acc;
        insn_t eb;
        eb = '0;
        eb.pc = 32'h8000_0100; eb.inst = 32'h0010_0073; eb.commit = 1'b1; eb.halt = 1'b1;
        step(eb, 1'b1, 1'b0, e, a, acc);
        step(rand_insn(1'b0), 1'b1, 1'b0, e, a, acc);
        n_checks++;
        if (a !== e || a.commit !== 1'b1 || a.pc !== 32'h8000_0100)
            $display("FAIL halt_commit: got %h want %h", a, e);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            step(rand_insn(1'b0), 1'b1, 1'b0, e, a, acc);
            n_checks++;
            if (a !== e || a.halt !== 1'b1 || a.ready !== 1'b0 || a.commit !== 1'b0)
                $display("FAIL halted_%0d: got %h want %h", k, a, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_ecall();
        obs_t e, a;
        logic acc;
        insn_t ec;
        ec = '0;
        ec.pc = 32'h8000_0200; ec.commit = 1'b1; ec.ecall = 1'b1;
        step(idle_i, 1'b0, 1'b1, e, a, acc);
        step(idle_i, 1'b0, 1'b0, e, a, acc);
        n_checks++;
        if (a !== e || a.halt !== 1'b0 || a.ready !== 1'b1)
            $display("FAIL reset_clears_halt: got %h want %h", a, e);
        else n_pass++;
        step(ec, 1'b1, 1'b0, e, a, acc);
        step(idle_i, 1'b0, 1'b1, e, a, acc);
        n_checks++;
        if (a !== e || a.csrwr !== 1'b1 || a.csr_rd !== 3'd3)
            $display("FAIL mid_ecall_mepc: got %h want %h", a, e);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            step(idle_i, 1'b0, 1'b0, e, a, acc);
            n_checks++;
            if (a !== e || {a.csrwr, a.regwr, a.halt, a.ready, a.csr_rd} !== {4'b0001, 3'd0})
                $display("FAIL mid_ecall_reset_%0d: got %h want %h", k, a, e);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(idle_i, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_add();
        test_load_x0();
        test_csrrw();
        test_ecall();
        test_back_to_back();
        test_random();
        test_halt();
        test_reset_mid_ecall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
